// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: per-master Wishbone requests/responses and the shared slave port.
// Modport master is the arbiter's view; modport slave is the view of the surrounding masters and slave.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i;
  logic [NUM_MASTERS*AW-1:0]     m_adr_i;
  logic [NUM_MASTERS*DW-1:0]     m_dat_i;
  logic [NUM_MASTERS*3-1:0]      m_cti_i;
  logic [NUM_MASTERS*2-1:0]      m_bte_i;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;
  logic [NUM_MASTERS-1:0]        m_rty_o;
  logic [DW-1:0]                 m_dat_o;

  logic                          s_cyc_o;
  logic                          s_stb_o;
  logic                          s_we_o;
  logic [DW/8-1:0]               s_sel_o;
  logic [AW-1:0]                 s_adr_o;
  logic [DW-1:0]                 s_dat_o;
  logic [2:0]                    s_cti_o;
  logic [1:0]                    s_bte_o;
  logic                          s_ack_i;
  logic                          s_err_i;
  logic                          s_rty_i;
  logic [DW-1:0]                 s_dat_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i, m_bte_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i, m_bte_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o, s_bte_o,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter: N masters share one slave port, grant held for the whole CYC.
// Optional stalled-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_rr_arbiter_if.master        bus,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   busy_o
);

  localparam int PW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          last_q, last_d;

  logic                   win_found;
  logic [PW-1:0]          win_idx;
  logic                   granted;
  logic                   stb_raw;
  logic                   resp;
  logic                   to_fire;

  // Scan upward from the master after the last winner, wrapping modulo NUM_MASTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!win_found && bus.m_cyc_i[(int'(last_q) + k) % NUM_MASTERS]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(last_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = NUM_MASTERS'(1) << win_idx;
          gidx_d  = win_idx;
          last_d  = win_idx;
        end
      end
      S_GRANT: begin
        // CYC is the lock: release only when the owner drops it, never preempt.
        if (!bus.m_cyc_i[gidx_q]) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= PW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == S_GRANT);
  assign granted = |gnt_q;
  assign stb_raw = granted && bus.m_cyc_i[gidx_q] && bus.m_stb_i[gidx_q];
  assign resp    = bus.s_ack_i || bus.s_err_i || bus.s_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = 16;

  logic [WD_W-1:0] wd_q;

  // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign to_fire = stb_raw && !resp && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
    end else if (!granted || (gnt_d != gnt_q) || resp || to_fire) begin
      wd_q <= '0;
    end else if (stb_raw) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`else
  // No watchdog; TIMEOUT_CYCLES is only meaningful when it is built in.
  assign to_fire = (TIMEOUT_CYCLES < 0);
`endif

  // Slave side follows the registered grant; everything is zero when idle.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (granted) begin
      bus.s_cyc_o = bus.m_cyc_i[gidx_q];
      bus.s_we_o  = bus.m_we_i[gidx_q];
      bus.s_sel_o = bus.m_sel_i[gidx_q*SW +: SW];
      bus.s_adr_o = bus.m_adr_i[gidx_q*AW +: AW];
      bus.s_dat_o = bus.m_dat_i[gidx_q*DW +: DW];
      bus.s_cti_o = bus.m_cti_i[gidx_q*3 +: 3];
      bus.s_bte_o = bus.m_bte_i[gidx_q*2 +: 2];
    end
  end

  assign bus.s_stb_o = stb_raw && !to_fire;
  assign bus.m_dat_o = bus.s_dat_i;

  always_comb begin
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    if (granted) begin
      bus.m_ack_o[gidx_q] = bus.s_ack_i;
      bus.m_err_o[gidx_q] = bus.s_err_i || to_fire;
      bus.m_rty_o[gidx_q] = bus.s_rty_i;
    end
  end

endmodule
